// File: rtl/lc3b_types.sv
// Shared LC-3b memory types: word, cache line and the number of word beats per line.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    localparam int unsigned LINE_BEATS = 8;
    localparam int unsigned CNT_W      = $clog2(LINE_BEATS);

endpackage

// File: rtl/line_responder_control.sv
// Line transfer sequencer: accepts a line request, walks eight word beats, pulses completion.
module line_responder_control
    import lc3b_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             beat_resp,
    output logic             accept,
    output logic             beat_read,
    output logic             beat_write,
    output logic             mem_resp,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic [1:0] {StIdle, StReadBeat, StWriteBeat, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_beat;

    assign last_beat = (cnt_q == CNT_W'(LINE_BEATS - 1));
    assign cnt       = cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        beat_read  = 1'b0;
        beat_write = 1'b0;
        mem_resp   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Read wins when both requests are raised together.
                if (mem_read) begin
                    state_d = StReadBeat;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else if (mem_write) begin
                    state_d = StWriteBeat;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end
            end
            StReadBeat: begin
                beat_read = 1'b1;
                if (beat_resp) begin
                    if (last_beat) state_d = StDone;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            StWriteBeat: begin
                beat_write = 1'b1;
                if (beat_resp) begin
                    if (last_beat) state_d = StDone;
                    else           cnt_d   = cnt_q + 1'b1;
                end
            end
            StDone: begin
                mem_resp = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/line_responder.sv
// Splits 128-bit line reads/writes into eight 16-bit backing-memory beats.
module line_responder
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  lc3b_c_line  mem_wdata,
    output logic        mem_resp,
    output lc3b_c_line  mem_rdata,
    output logic        beat_read,
    output logic        beat_write,
    output logic [15:0] beat_address,
    output lc3b_word    beat_wdata,
    input  lc3b_word    beat_rdata,
    input  logic        beat_resp
);

    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       beat_lsb;

    logic [11:0] line_addr_q, line_addr_d;
    lc3b_c_line  line_wdata_q, line_wdata_d;
    lc3b_c_line  line_rdata_q, line_rdata_d;

    // Line offset bits never reach the backing memory.
    logic unused_addr;
    assign unused_addr = ^mem_address[3:0];

    line_responder_control u_control (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .beat_resp  (beat_resp),
        .accept     (accept),
        .beat_read  (beat_read),
        .beat_write (beat_write),
        .mem_resp   (mem_resp),
        .cnt        (cnt)
    );

    assign beat_lsb = {cnt, 4'b0000};

    always_comb begin
        line_addr_d  = line_addr_q;
        line_wdata_d = line_wdata_q;
        line_rdata_d = line_rdata_q;
        if (accept) begin
            line_addr_d  = mem_address[15:4];
            line_wdata_d = mem_wdata;
        end
        if (beat_read && beat_resp) begin
            line_rdata_d[beat_lsb +: 16] = beat_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_addr_q  <= '0;
            line_wdata_q <= '0;
            line_rdata_q <= '0;
        end else begin
            line_addr_q  <= line_addr_d;
            line_wdata_q <= line_wdata_d;
            line_rdata_q <= line_rdata_d;
        end
    end

    assign beat_address = {line_addr_q, cnt, 1'b0};
    assign beat_wdata   = line_wdata_q[beat_lsb +: 16];
    assign mem_rdata    = mem_resp ? line_rdata_q : '0;

endmodule

// File: tb/tb_line_responder.sv
// Directed bench for line_responder: read, waited write, arbitration, back-to-back, reset, drop.
module tb_line_responder;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    lc3b_c_line  mem_wdata;
    logic        mem_resp;
    lc3b_c_line  mem_rdata;
    logic        beat_read, beat_write;
    logic [15:0] beat_address;
    lc3b_word    beat_wdata, beat_rdata;
    logic        beat_resp;

    int checks = 0;
    int failures = 0;

    int resp_cnt = 0;
    int consec_cnt = 0;
    int overlap_cnt = 0;
    int seen_write = 0;
    logic prev_resp = 1'b0;
    int base;

    always #5 clk = ~clk;

    line_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .beat_read    (beat_read),
        .beat_write   (beat_write),
        .beat_address (beat_address),
        .beat_wdata   (beat_wdata),
        .beat_rdata   (beat_rdata),
        .beat_resp    (beat_resp)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_resp) resp_cnt++;
            if (mem_resp && prev_resp) consec_cnt++;
            if (beat_read && beat_write) overlap_cnt++;
            if (beat_write) seen_write++;
            prev_resp = mem_resp;
        end else begin
            prev_resp = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_resp"}, 128'(mem_resp), 128'd0);
        check({tag, "_bread"}, 128'(beat_read), 128'd0);
        check({tag, "_bwrite"}, 128'(beat_write), 128'd0);
        check({tag, "_rdata"}, mem_rdata, 128'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        beat_rdata  = '0;
        beat_resp   = 1'b0;

        // Reset state
        #12;
        check_idle_outputs("rst");
        check("rst_baddr", 128'(beat_address), 128'd0);
        check("rst_bwdata", 128'(beat_wdata), 128'd0);
        #10 rst_n = 1'b1;
        tick();
        // beat_resp in IDLE must be ignored
        beat_resp = 1'b1;
        tick();
        check_idle_outputs("idle_bresp");

        // Read, zero wait
        mem_read    = 1'b1;
        mem_address = 16'h1234;
        tick();
        for (int b = 0; b < 8; b++) begin
            beat_rdata = 16'h00A0 + 16'(b);
            check($sformatf("rd_baddr%0d", b), 128'(beat_address), 128'(16'h1230 + 16'(2 * b)));
            check($sformatf("rd_bread%0d", b), 128'(beat_read), 128'd1);
            check($sformatf("rd_noresp%0d", b), 128'(mem_resp), 128'd0);
            tick();
        end
        check("rd_resp", 128'(mem_resp), 128'd1);
        check("rd_line", mem_rdata,
              128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
        mem_read = 1'b0;
        tick();
        check_idle_outputs("rd_after");

        // Write with waits: beat_resp every third cycle
        base      = resp_cnt;
        beat_resp = 1'b0;
        mem_write = 1'b1;
        mem_wdata = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        tick();
        mem_wdata = '1;
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 3; w++) begin
                beat_resp = (w == 2);
                check($sformatf("wr_bwdata%0d_%0d", b, w), 128'(beat_wdata),
                      128'(16'h1111 * 16'(b)));
                check($sformatf("wr_bwrite%0d_%0d", b, w), 128'(beat_write), 128'd1);
                tick();
            end
        end
        beat_resp = 1'b0;
        check("wr_resp", 128'(mem_resp), 128'd1);
        check("wr_rdata_keep", mem_rdata,
              128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
        mem_write = 1'b0;
        tick();
        tick();
        check("wr_resp_once", 128'(resp_cnt - base), 128'd1);

        // Simultaneous read and write
        seen_write  = 0;
        base        = resp_cnt;
        beat_resp   = 1'b1;
        mem_read    = 1'b1;
        mem_write   = 1'b1;
        mem_address = 16'h5550;
        tick();
        check("sim_bread", 128'(beat_read), 128'd1);
        for (int i = 0; i < 8; i++) tick();
        check("sim_resp", 128'(mem_resp), 128'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        tick();
        check("sim_no_write", 128'(seen_write), 128'd0);
        check("sim_resp_once", 128'(resp_cnt - base), 128'd1);

        // Back-to-back: request held through mem_resp
        mem_read    = 1'b1;
        mem_address = 16'h2000;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("b2b_resp1", 128'(mem_resp), 128'd1);
        tick();
        check_idle_outputs("b2b_idle");
        tick();
        check("b2b_bread2", 128'(beat_read), 128'd1);
        check("b2b_baddr2", 128'(beat_address), 128'h2000);
        mem_read = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("b2b_resp2", 128'(mem_resp), 128'd1);
        tick();
        check("b2b_consec", 128'(consec_cnt), 128'd0);

        // Reset mid-read at cnt=4
        mem_read    = 1'b1;
        mem_address = 16'h4440;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("rr_baddr4", 128'(beat_address), 128'h4448);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rr_rst");
        check("rr_baddr", 128'(beat_address), 128'd0);
        check("rr_bwdata", 128'(beat_wdata), 128'd0);
        mem_read = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        base = resp_cnt;
        for (int i = 0; i < 12; i++) tick();
        check("rr_no_resp", 128'(resp_cnt - base), 128'd0);
        mem_read = 1'b1;
        tick();
        check("rr_new_baddr", 128'(beat_address), 128'h4440);
        check("rr_new_bread", 128'(beat_read), 128'd1);
        mem_read = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rr_new_resp", 128'(mem_resp), 128'd1);
        tick();

        // Request dropped at cnt=2
        base        = resp_cnt;
        mem_read    = 1'b1;
        mem_address = 16'h6660;
        tick();
        tick();
        tick();
        mem_read = 1'b0;
        for (int b = 2; b < 8; b++) begin
            check($sformatf("drop_baddr%0d", b), 128'(beat_address), 128'(16'h6660 + 16'(2 * b)));
            check($sformatf("drop_bread%0d", b), 128'(beat_read), 128'd1);
            tick();
        end
        check("drop_resp", 128'(mem_resp), 128'd1);
        tick();
        tick();
        check("drop_resp_once", 128'(resp_cnt - base), 128'd1);
        check("overlap", 128'(overlap_cnt), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
